// File: rtl/dm_bus_ctrl_if.sv
// Data-memory bus between the CPU-side bus controller (master) and the memory slave.
// One aligned 32-bit request at a time, completed by a single-cycle bus_ready.
interface dm_bus_ctrl_if;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/dm_bus_ctrl.sv
// Data-memory bus controller: turns one CPU load/store into one aligned bus transaction,
// stalls the CPU until the slave answers, formats load data and flags misalign/timeout.
module dm_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              mem_w,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       wdata_in,
    input  logic [2:0]        dm_ctrl,
    output logic [31:0]       rdata_out,
    output logic              stall,
    output logic              misalign_err,
    output logic              timeout_err,
    dm_bus_ctrl_if.master     bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // The counter reaches TIMEOUT_CYCLES on the edge that leaves BUS, so compare against one less.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    function automatic logic [1:0] size_of(input logic [2:0] ctrl);
        case (ctrl)
            3'b001, 3'b010: size_of = SZ_HALF;
            3'b011, 3'b100: size_of = SZ_BYTE;
            default:        size_of = SZ_WORD;
        endcase
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  next_state_s;
    logic [7:0]  cnt_r;
    logic [1:0]  off_r;
    logic [2:0]  ctrl_r;

    logic [1:0]  req_size_s;
    logic        misalign_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [15:0] half_s;
    logic [7:0]  byte_s;
    logic [31:0] load_fmt_s;
    logic        start_bus_s;
    logic        load_done_s;
    logic        mis_hit_s;
    logic        to_hit_s;

    assign stall = reset & cpu_req & (state_r != ST_RESP);

    // Request decode: misalignment, byte enables and lane-replicated store data.
    always_comb begin
        req_size_s = size_of(dm_ctrl);
        misalign_s = 1'b0;
        be_s       = 4'b1111;
        wdata_s    = 32'h0000_0000;
        case (req_size_s)
            SZ_WORD: begin
                misalign_s = (addr_in[1:0] != 2'b00);
                wdata_s    = wdata_in;
            end
            SZ_HALF: begin
                misalign_s = addr_in[0];
                be_s       = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_s    = {2{wdata_in[15:0]}};
            end
            default: begin
                be_s    = 4'b0001 << addr_in[1:0];
                wdata_s = {4{wdata_in[7:0]}};
            end
        endcase
        if (!mem_w) begin
            be_s    = 4'b1111;
            wdata_s = 32'h0000_0000;
        end else begin
            be_s    = be_s;
            wdata_s = wdata_s;
        end
    end

    // Load formatting from the captured lane offset and access type.
    always_comb begin
        half_s = off_r[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (off_r)
            2'd0:    byte_s = bus.bus_rdata[7:0];
            2'd1:    byte_s = bus.bus_rdata[15:8];
            2'd2:    byte_s = bus.bus_rdata[23:16];
            default: byte_s = bus.bus_rdata[31:24];
        endcase
        case (ctrl_r)
            3'b001:  load_fmt_s = {{16{half_s[15]}}, half_s};
            3'b010:  load_fmt_s = {16'h0000, half_s};
            3'b011:  load_fmt_s = {{24{byte_s[7]}}, byte_s};
            3'b100:  load_fmt_s = {24'h00_0000, byte_s};
            default: load_fmt_s = bus.bus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; bus_ready takes priority over the timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req) begin
                    next_state_s = misalign_s ? ST_RESP : ST_BUS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (bus.bus_ready || (cnt_r == TO_LAST)) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_BUS;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: events that update the registered outputs on this edge.
    always_comb begin
        start_bus_s = 1'b0;
        load_done_s = 1'b0;
        mis_hit_s   = 1'b0;
        to_hit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_bus_s = cpu_req & ~misalign_s;
                mis_hit_s   = cpu_req & misalign_s;
            end
            ST_BUS: begin
                load_done_s = bus.bus_ready & ~bus.bus_we;
                to_hit_s    = ~bus.bus_ready & (cnt_r == TO_LAST);
            end
            default: begin
                start_bus_s = 1'b0;
            end
        endcase
    end

    // Registered bus request, captured access info, timeout counter and CPU-facing outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.bus_valid <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0000_0000;
            bus.bus_be    <= 4'b0000;
            bus.bus_wdata <= 32'h0000_0000;
            off_r         <= 2'b00;
            ctrl_r        <= 3'b000;
            cnt_r         <= 8'd0;
            rdata_out     <= 32'h0000_0000;
            misalign_err  <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            bus.bus_valid <= (next_state_s == ST_BUS);
            misalign_err  <= mis_hit_s;
            timeout_err   <= to_hit_s;
            if (start_bus_s) begin
                bus.bus_we    <= mem_w;
                bus.bus_addr  <= {addr_in[31:2], 2'b00};
                bus.bus_be    <= be_s;
                bus.bus_wdata <= wdata_s;
                off_r         <= addr_in[1:0];
                ctrl_r        <= dm_ctrl;
            end
            if ((state_r == ST_BUS) && !bus.bus_ready) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= 8'd0;
            end
            if (load_done_s) begin
                rdata_out <= load_fmt_s;
            end else if (mis_hit_s || to_hit_s) begin
                rdata_out <= 32'h0000_0000;
            end
        end
    end

endmodule
